phase_freq_detector: RTL and testbench

//  Synchronous tri-state phase/frequency detector for the PLL2 loop.

---
 rtl/pll_pkg.sv | 14 +
 rtl/phase_freq_detector_edge_sync.sv | 29 ++
 rtl/phase_freq_detector.sv | 83 ++++++++
 tb/tb_phase_freq_detector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL2 loop blocks: detector state encoding and
// the direction values carried on setting[1].
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } pfd_state_t;

    localparam logic SETTING_UP = 1'b1;
    localparam logic SETTING_DN = 1'b0;

endpackage

// File: rtl/phase_freq_detector_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, with a rising-edge
// strobe taken from the last stage against one extra delayed copy.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (nrst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~prev;

endmodule

// File: rtl/phase_freq_detector.sv
// Tri-state phase/frequency detector: up/dn pulse width equals the lag in clk
// cycles between synchronized link and vco rising edges.
module phase_freq_detector
    import pll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_PULSE   = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       link,
    input  logic       vco,
    output logic [1:0] setting,
    output logic       up,
    output logic       dn,
    output logic       upb,
    output logic       dnb
);

    pfd_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             rl, rv;
    logic             link_q, vco_q;
    logic             unused_q;
    logic             timeout;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_link_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (link),
        .q    (link_q),
        .rise (rl)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vco_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (vco),
        .q    (vco_q),
        .rise (rv)
    );

    assign unused_q = link_q ^ vco_q;

    // Age counter reads 0 in the first pulse cycle, so the limit compares against MAX_PULSE-1.
    assign timeout = (MAX_PULSE != 0) && (cnt == CNT_W'(MAX_PULSE - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rl && !rv)      state_nx = UP;
                else if (rv && !rl) state_nx = DN;
            end
            UP:      if (rv || timeout) state_nx = IDLE;
            DN:      if (rl || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == UP) dir <= SETTING_UP;
            if (state == IDLE && state_nx == DN) dir <= SETTING_DN;
            if (state == IDLE || state_nx == IDLE) cnt <= '0;
            else if (cnt != '1)                    cnt <= cnt + 1'b1;
        end
    end

    assign up      = (state == UP);
    assign dn      = (state == DN);
    assign upb     = ~up;
    assign dnb     = ~dn;
    assign setting = {dir, up | dn};

endmodule

// File: tb/tb_phase_freq_detector.sv
// Directed bench for phase_freq_detector: two instances (no pulse limit and a
// 16-cycle limit) share stimulus and are checked every cycle against a model.
module tb_phase_freq_detector;

    logic       clk = 1'b0;
    logic       nrst, link, vco;
    logic [1:0] set0, set1;
    logic       up0, dn0, upb0, dnb0;
    logic       up1, dn1, upb1, dnb1;

    int checks = 0;
    int errors = 0;

    phase_freq_detector #(.SYNC_STAGES(2), .MAX_PULSE(0), .CNT_W(32)) dut0 (
        .clk(clk), .nrst(nrst), .link(link), .vco(vco),
        .setting(set0), .up(up0), .dn(dn0), .upb(upb0), .dnb(dnb0)
    );

    phase_freq_detector #(.SYNC_STAGES(2), .MAX_PULSE(16), .CNT_W(32)) dut1 (
        .clk(clk), .nrst(nrst), .link(link), .vco(vco),
        .setting(set1), .up(up1), .dn(dn1), .upb(upb1), .dnb(dnb1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: an edge sampled at posedge n is acted on at posedge n+2.
    // A pulse is described by polarity and how many cycles it has been high.
    logic [2:0] lh = '0, vh = '0;
    int         maxp [2] = '{0, 16};
    int         m_age[2] = '{0, 0};
    bit         m_pol[2] = '{0, 0};
    bit         m_dir[2] = '{0, 0};
    int         m_last[2] = '{0, 0};
    bit         started = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        bit rl, rv;
        cyc++;
        started = 1;
        rl = lh[1] & ~lh[2];
        rv = vh[1] & ~vh[2];
        if (nrst) begin
            lh = '0;
            vh = '0;
        end else begin
            lh = {lh[1:0], link};
            vh = {vh[1:0], vco};
        end
        for (int i = 0; i < 2; i++) begin
            if (nrst) begin
                m_age[i] = 0; m_pol[i] = 0; m_dir[i] = 0;
            end else if (m_age[i] == 0) begin
                if (rl && !rv)      begin m_age[i] = 1; m_pol[i] = 1; m_dir[i] = 1; end
                else if (rv && !rl) begin m_age[i] = 1; m_pol[i] = 0; m_dir[i] = 0; end
            end else if ((m_pol[i] && rv) || (!m_pol[i] && rl) ||
                         (maxp[i] != 0 && m_age[i] == maxp[i])) begin
                m_last[i] = m_age[i];
                m_age[i]  = 0;
            end else if (m_age[i] < 1000000) begin
                m_age[i]++;
            end
        end
    end

    int up_cnt0, dn_cnt0, up_cnt1, up_first;

    always @(negedge clk) begin
        if (started) begin
            int eu0, ed0, eu1, ed1;
            eu0 = (m_age[0] != 0 && m_pol[0]) ? 1 : 0;
            ed0 = (m_age[0] != 0 && !m_pol[0]) ? 1 : 0;
            eu1 = (m_age[1] != 0 && m_pol[1]) ? 1 : 0;
            ed1 = (m_age[1] != 0 && !m_pol[1]) ? 1 : 0;
            chk("up0", int'(up0), eu0);
            chk("dn0", int'(dn0), ed0);
            chk("upb0", int'(upb0), 1 - eu0);
            chk("dnb0", int'(dnb0), 1 - ed0);
            chk("setting0", int'(set0), int'(m_dir[0]) * 2 + (eu0 | ed0));
            chk("up1", int'(up1), eu1);
            chk("dn1", int'(dn1), ed1);
            chk("upb1", int'(upb1), 1 - eu1);
            chk("dnb1", int'(dnb1), 1 - ed1);
            chk("setting1", int'(set1), int'(m_dir[1]) * 2 + (eu1 | ed1));
            chk("exclusive0", int'(up0 & dn0), 0);
            if (up0) up_cnt0++;
            if (dn0) dn_cnt0++;
            if (up1) up_cnt1++;
            if (up0 && up_first < 0) up_first = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        up_cnt0 = 0; dn_cnt0 = 0; up_cnt1 = 0; up_first = -1;
    endtask

    initial begin
        int c0;
        nrst = 1'b1; link = 1'b0; vco = 1'b0;
        clear_counts();

        // Reset held while inputs toggle
        repeat (4) begin
            tick();
            link = ~link;
            vco  = ~vco;
        end
        tick();
        chk("reset_up", int'(up0), 0);
        chk("reset_setting", int'(set0), 0);
        chk("reset_upb", int'(upb0), 1);
        link = 1'b0; vco = 1'b0;
        tick();
        nrst = 1'b0;
        repeat (5) tick();

        // Lag: vco leads link by 7
        clear_counts();
        vco = 1'b1;
        repeat (7) tick();
        link = 1'b1;
        repeat (15) tick();
        chk("lag_dn_width", dn_cnt0, 7);
        chk("lag_up_width", up_cnt0, 0);
        chk("lag_model_width", m_last[0], 7);
        chk("lag_setting_after", int'(set0), 0);
        link = 1'b0; vco = 1'b0;
        repeat (5) tick();

        // Lead: link leads vco by 10
        clear_counts();
        c0 = cyc;
        link = 1'b1;
        repeat (10) tick();
        vco = 1'b1;
        repeat (20) tick();
        chk("lead_latency", up_first - c0, 3);
        chk("lead_up_width", up_cnt0, 10);
        chk("lead_up_width_lim", up_cnt1, 10);
        chk("lead_dn_width", dn_cnt0, 0);
        chk("lead_model_width", m_last[0], 10);
        chk("lead_setting_after", int'(set0), 2);
        link = 1'b0; vco = 1'b0;
        repeat (5) tick();

        // Simultaneous edges: no pulse, direction retained
        clear_counts();
        link = 1'b1; vco = 1'b1;
        repeat (10) tick();
        chk("simul_pulses", up_cnt0 + dn_cnt0, 0);
        chk("simul_setting", int'(set0), 2);
        link = 1'b0; vco = 1'b0;
        repeat (5) tick();

        // Timeout on dut1, unlimited on dut0
        clear_counts();
        link = 1'b1;
        repeat (40) tick();
        chk("timeout_width", up_cnt1, 16);
        chk("timeout_closed", int'(up1), 0);
        chk("nolimit_open", int'(up0), 1);
        chk("nolimit_width", up_cnt0, 38);
        nrst = 1'b1; link = 1'b0;
        tick();
        nrst = 1'b0;
        repeat (4) tick();

        // Mid-pulse reset in 4th pulse cycle, then a fresh 5-cycle pulse
        clear_counts();
        link = 1'b1;
        repeat (6) tick();
        chk("mid_up_before", int'(up0), 1);
        chk("mid_width_before", up_cnt0, 4);
        nrst = 1'b1; link = 1'b0;
        tick();
        chk("mid_up_after", int'(up0), 0);
        chk("mid_setting_after", int'(set0), 0);
        nrst = 1'b0;
        repeat (4) tick();
        clear_counts();
        link = 1'b1;
        repeat (5) tick();
        vco = 1'b1;
        repeat (10) tick();
        chk("fresh_width", up_cnt0, 5);
        chk("fresh_width_lim", up_cnt1, 5);
        chk("fresh_model_width", m_last[1], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
